// File: rtl/exec_alu_unit.sv
// ---------------------------------------------------------------------------
// exec_alu_unit
//
// Registered execute stage for the single-cycle MIPS-style datapath.
// It decodes the 3-bit ALU control code from the main-control ALUop bits and
// the function field, runs the ALU with zero/carry/negative flags, and forms
// the sequential PC and the branch target. Every result is captured in a
// single output register stage.
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset, clears every output
//   in_valid   : operands presented this cycle are valid
//   aluop      : {aluop1, aluop0} from main control
//   funct      : instruction bits [3:0]
//   op_a       : register-file read port A
//   op_b       : second ALU operand (register or immediate)
//   pc         : current program counter
//   imm16      : branch offset in words (instruction bits [15:0])
//   out_valid  : registered in_valid
//   result     : registered ALU result
//   zero       : registered "result is zero" flag
//   carry      : registered carry out of add/subtract
//   neg        : registered result MSB
//   gctl       : registered decoded ALU control code
//   pc_plus4   : registered pc + 4
//   br_target  : registered pc + 4 + (sext(imm16) << 2)
// ---------------------------------------------------------------------------
module exec_alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       aluop,
  input  logic [3:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] pc,
  input  logic [15:0]      imm16,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             neg,
  output logic [2:0]       gctl,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] br_target
);

  localparam logic [2:0] CodeAnd = 3'b000;
  localparam logic [2:0] CodeOr  = 3'b001;
  localparam logic [2:0] CodeAdd = 3'b010;
  localparam logic [2:0] CodeSub = 3'b110;
  localparam logic [2:0] CodeSlt = 3'b111;

  logic [2:0]       w_gctl;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_slt;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_br_target;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_neg;
  logic [2:0]       r_gctl;
  logic [WIDTH-1:0] r_pc_plus4;
  logic [WIDTH-1:0] r_br_target;

  // ALU control decode. The assignments are ordered so that a later matching
  // rule overrides an earlier one. Starting from add covers both aluop == 00
  // and an R-type funct that matches no line.
  always_comb begin
    w_gctl = CodeAdd;
    if (aluop[0]) w_gctl = CodeSub;
    if (aluop[1]) begin
      if (funct == 4'b0000)        w_gctl = CodeAdd;
      if (funct[3] && funct[1])    w_gctl = CodeSlt;
      if (!funct[3] && funct[1])   w_gctl = CodeSub;
      if (funct[2] && funct[0])    w_gctl = CodeOr;
      if (funct[2] && !funct[0])   w_gctl = CodeAnd;
    end
  end

  // Shared adders. Subtraction is a + ~b + 1, so its carry out is 1 when no
  // borrow occurs; set-less-than reuses that carry.
  assign w_sum  = {1'b0, op_a} + {1'b0, op_b};
  assign w_diff = {1'b0, op_a} + {1'b0, ~op_b} + (WIDTH+1)'(1);
  assign w_slt  = $signed(op_a) < $signed(op_b);

  // Result and carry selection by control code; unused codes produce zero.
  always_comb begin
    w_result = '0;
    w_carry  = 1'b0;
    case (w_gctl)
      CodeAnd: w_result = op_a & op_b;
      CodeOr:  w_result = op_a | op_b;
      CodeAdd: begin
        w_result = w_sum[WIDTH-1:0];
        w_carry  = w_sum[WIDTH];
      end
      CodeSub: begin
        w_result = w_diff[WIDTH-1:0];
        w_carry  = w_diff[WIDTH];
      end
      CodeSlt: begin
        w_result = {{(WIDTH-1){1'b0}}, w_slt};
        w_carry  = w_diff[WIDTH];
      end
      default: begin
        w_result = '0;
        w_carry  = 1'b0;
      end
    endcase
  end

  // Address adders: the branch offset is in words, so it is sign-extended
  // and shifted left by two before being added to the sequential PC.
  assign w_pc_plus4  = pc + WIDTH'(4);
  assign w_br_target = w_pc_plus4 + {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};

  // Output stage: loads on every edge regardless of in_valid; out_valid
  // tells downstream which cycles carry meaningful data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_neg       <= 1'b0;
      r_gctl      <= 3'b000;
      r_pc_plus4  <= '0;
      r_br_target <= '0;
    end else begin
      r_out_valid <= in_valid;
      r_result    <= w_result;
      r_zero      <= ~|w_result;
      r_carry     <= w_carry;
      r_neg       <= w_result[WIDTH-1];
      r_gctl      <= w_gctl;
      r_pc_plus4  <= w_pc_plus4;
      r_br_target <= w_br_target;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign neg       = r_neg;
  assign gctl      = r_gctl;
  assign pc_plus4  = r_pc_plus4;
  assign br_target = r_br_target;

endmodule

// File: tb/tb_exec_alu_unit.sv
// ---------------------------------------------------------------------------
// tb_exec_alu_unit
//
// Self-checking bench for exec_alu_unit. Directed vectors cover reset,
// decode, arithmetic wrap and flags; a randomized loop compares every output
// with a behavioural model built from the decode rules and plain arithmetic.
// ---------------------------------------------------------------------------
module tb_exec_alu_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  aluop;
  logic [3:0]  funct;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] pc;
  logic [15:0] imm16;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        carry;
  logic        neg;
  logic [2:0]  gctl;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;

  int errCount   = 0;
  int checkCount = 0;

  exec_alu_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .aluop     (aluop),
    .funct     (funct),
    .op_a      (op_a),
    .op_b      (op_b),
    .pc        (pc),
    .imm16     (imm16),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .neg       (neg),
    .gctl      (gctl),
    .pc_plus4  (pc_plus4),
    .br_target (br_target)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference decode: the last matching rule wins, so the rules are tested
  // from last to first and the first hit is returned.
  function automatic logic [2:0] refCode(input logic [1:0] ao, input logic [3:0] fn);
    if (ao[1]) begin
      if (fn[2] && !fn[0]) return 3'b000;
      if (fn[2] && fn[0])  return 3'b001;
      if (!fn[3] && fn[1]) return 3'b110;
      if (fn[3] && fn[1])  return 3'b111;
      if (fn == 4'd0)      return 3'b010;
    end
    if (ao[0]) return 3'b110;
    return 3'b010;
  endfunction

  // Reference ALU using wide integer arithmetic and signed comparison.
  task automatic refAlu(input logic [2:0] code, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res,
                        output logic car);
    longint s;
    res = 32'd0;
    car = 1'b0;
    case (code)
      3'b000: res = a & b;
      3'b001: res = a | b;
      3'b010: begin
        s   = longint'(a) + longint'(b);
        res = s[31:0];
        car = s[32];
      end
      3'b110: begin
        res = a - b;
        car = (a >= b);
      end
      3'b111: begin
        res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        car = (a >= b);
      end
      default: begin
        res = 32'd0;
        car = 1'b0;
      end
    endcase
  endtask

  // Drive one operation mid-cycle, then step past the next rising edge.
  task automatic applyStimulus(input logic v, input logic [1:0] ao, input logic [3:0] fn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] p, input logic [15:0] im);
    in_valid = v;
    aluop    = ao;
    funct    = fn;
    op_a     = a;
    op_b     = b;
    pc       = p;
    imm16    = im;
    @(posedge clk);
    #1;
  endtask

  // Compare every output with the model evaluated on the held inputs.
  task automatic checkAll(input string tag);
    logic [2:0]  expCode;
    logic [31:0] expRes;
    logic        expCar;
    logic [31:0] expP4;
    logic [31:0] expBr;
    expCode = refCode(aluop, funct);
    refAlu(expCode, op_a, op_b, expRes, expCar);
    expP4 = pc + 32'd4;
    expBr = expP4 + 32'(int'($signed(imm16)) * 4);
    checkOutput({tag, ".gctl"},   32'(gctl),      32'(expCode));
    checkOutput({tag, ".result"}, result,         expRes);
    checkOutput({tag, ".carry"},  32'(carry),     32'(expCar));
    checkOutput({tag, ".zero"},   32'(zero),      32'(expRes == 32'd0));
    checkOutput({tag, ".neg"},    32'(neg),       32'(expRes[31]));
    checkOutput({tag, ".valid"},  32'(out_valid), 32'(in_valid));
    checkOutput({tag, ".pc4"},    pc_plus4,       expP4);
    checkOutput({tag, ".br"},     br_target,      expBr);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".result"}, result,         32'd0);
    checkOutput({tag, ".zero"},   32'(zero),      32'd0);
    checkOutput({tag, ".carry"},  32'(carry),     32'd0);
    checkOutput({tag, ".neg"},    32'(neg),       32'd0);
    checkOutput({tag, ".gctl"},   32'(gctl),      32'd0);
    checkOutput({tag, ".pc4"},    pc_plus4,       32'd0);
    checkOutput({tag, ".br"},     br_target,      32'd0);
    checkOutput({tag, ".valid"},  32'(out_valid), 32'd0);
  endtask

  // Main sequence: reset, directed vectors, async reset, valid tracking,
  // randomized sweep, summary.
  initial begin
    logic [3:0]  sweepFunct [6];
    logic [2:0]  sweepCode  [6];
    logic [31:0] corners    [6];
    logic        prevValid;
    logic        nextValid;
    logic [31:0] ra;
    logic [31:0] rb;

    sweepFunct = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b1010, 4'b0110};
    sweepCode  = '{3'b010,  3'b110,  3'b000,  3'b001,  3'b111,  3'b000};
    corners    = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h12345678};

    rst_n    = 1'b0;
    in_valid = 1'b1;
    aluop    = 2'b01;
    funct    = 4'h0;
    op_a     = 32'h5;
    op_b     = 32'h3;
    pc       = 32'h100;
    imm16    = 16'h1;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("rst_hold");

    rst_n = 1'b1;
    applyStimulus(1'b1, 2'b00, 4'h0, 32'h0, 32'h0, 32'h0, 16'h0);
    checkOutput("rst_release.pc4", pc_plus4, 32'd4);
    checkAll("rst_release");

    applyStimulus(1'b1, 2'b00, 4'h7, 32'h10, 32'h4, 32'h40, 16'h0);
    checkOutput("lwsw.gctl", 32'(gctl), 32'h2);
    checkOutput("lwsw.result", result, 32'h14);
    checkOutput("lwsw.zero", 32'(zero), 32'd0);
    checkOutput("lwsw.carry", 32'(carry), 32'd0);

    applyStimulus(1'b1, 2'b01, 4'h0, 32'h1234, 32'h1234, 32'h8, 16'hFFFE);
    checkOutput("beq.gctl", 32'(gctl), 32'h6);
    checkOutput("beq.result", result, 32'd0);
    checkOutput("beq.zero", 32'(zero), 32'd1);
    checkOutput("beq.carry", 32'(carry), 32'd1);
    checkOutput("beq.br", br_target, 32'h4);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 2'b10, sweepFunct[i], 32'h00FF00FF, 32'h0F0F0F0F, 32'h200, 16'h10);
      checkOutput($sformatf("sweep%0d.gctl", i), 32'(gctl), 32'(sweepCode[i]));
      checkAll($sformatf("sweep%0d", i));
    end

    applyStimulus(1'b1, 2'b10, 4'b1010, 32'hFFFFFFFF, 32'h1, 32'h0, 16'h0);
    checkOutput("slt_neg.result", result, 32'd1);
    applyStimulus(1'b1, 2'b10, 4'b1010, 32'h1, 32'hFFFFFFFF, 32'h0, 16'h0);
    checkOutput("slt_pos.result", result, 32'd0);
    checkOutput("slt_pos.zero", 32'(zero), 32'd1);

    applyStimulus(1'b1, 2'b00, 4'h0, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFC, 16'h0);
    checkOutput("wrap.result", result, 32'd0);
    checkOutput("wrap.carry", 32'(carry), 32'd1);
    checkOutput("wrap.zero", 32'(zero), 32'd1);
    checkOutput("wrap.pc4", pc_plus4, 32'd0);

    applyStimulus(1'b1, 2'b10, 4'b0100, 32'hF0F0F0F0, 32'h8F0F0F0F, 32'h300, 16'h7FFF);
    checkOutput("and.result", result, 32'h80000000);
    checkOutput("and.neg", 32'(neg), 32'd1);
    checkAll("and");

    // Registers are nonzero here; reset mid-cycle must clear them at once.
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("rst_async");
    @(negedge clk);
    checkAllZero("rst_async_hold");
    rst_n = 1'b1;
    applyStimulus(1'b1, 2'b01, 4'h0, 32'h9, 32'h2, 32'h1000, 16'h8000);
    checkAll("post_async");

    // out_valid must keep its old value until the edge, then follow in_valid.
    for (int i = 0; i < 20; i++) begin
      prevValid = in_valid;
      nextValid = 1'($urandom_range(0, 1));
      in_valid  = nextValid;
      #1;
      checkOutput("valid_hold", 32'(out_valid), 32'(prevValid));
      @(posedge clk);
      #1;
      checkOutput("valid_delay", 32'(out_valid), 32'(nextValid));
    end

    for (int i = 0; i < 200; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 7) == 0) rb = ra;
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)), ra, rb, $urandom, 16'($urandom));
      checkAll($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/exec_alu_unit.md
# exec_alu_unit

Registered execute-stage block for the single-cycle MIPS-style processor. It decodes the ALU control code from the main-control ALUop bits and the instruction function field, and performs the 32-bit ALU operation with zero/carry/negative flags. It also computes the sequential PC (`pc+4`) and the branch target. All results are captured in one output register stage, whose outputs feed the PC-select, memory and write-back muxes.

## Interface
Parameters:
- `WIDTH`, default 32: datapath width. Only 32 is required to be supported.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: the operands on the inputs this cycle are valid.
- `aluop` input 2: `{aluop1, aluop0}` from main control.
- `funct` input 4: instruction bits [3:0].
- `op_a` input 32: register-file read port A.
- `op_b` input 32: second ALU operand (output of the register/immediate mux).
- `pc` input 32: current program counter.
- `imm16` input 16: instruction bits [15:0], the branch offset in words.
- `out_valid` output 1: registered `in_valid`.
- `result` output 32: registered ALU result.
- `zero` output 1: registered, 1 when the ALU result is 0.
- `carry` output 1: registered carry out of the add or subtract operation.
- `neg` output 1: registered `result[31]`.
- `gctl` output 3: registered decoded ALU control code.
- `pc_plus4` output 32: registered `pc + 4`.
- `br_target` output 32: registered `pc + 4 + (sext(imm16) << 2)`.

## Operation
ALU control decode is combinational. Evaluate the rules in the order listed; a later matching rule overrides an earlier one. Bits are `f3..f0 = funct[3:0]`.
1. If `aluop == 00`: code 010 (add).
2. If `aluop0 = 1`: code 110 (sub).
3. If `aluop1 = 1`, decode `funct`; each matching line overrides the previous:
   - `funct == 0000` → 010.
   - `f3 & f1` → 111.
   - `~f3 & f1` → 110.
   - `f2 & f0` → 001.
   - `f2 & ~f0` → 000.
   - If no `funct` line matches, the code stays 110 when `aluop0 = 1` and is 010 when `aluop == 10`.

ALU operations, selected by the code:
- 000: `a & b`.
- 001: `a | b`.
- 010: `a + b`; `carry` = bit 32 of the sum.
- 110: `a - b`, computed as `a + ~b + 1`; `carry` = bit 32 (1 means no borrow).
- 111: set-less-than, signed two's-complement. Result is `32'd1` when `a < b`, else 0. `carry` = the carry of `a - b`.
- Any other code (011, 100, 101): result 0, `carry` 0.

Flags:
- `zero` = NOR of all result bits.
- `neg` = `result[31]`.
- Arithmetic wraps modulo 2^32; there is no overflow trap.

Address adders:
- `pc_plus4 = pc + 32'h4`, modulo 2^32.
- `br_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00}`, modulo 2^32.

## Timing
- Latency is 1 cycle. The values presented before rising edge N appear on the outputs after edge N.
- Every output register loads on every rising edge, regardless of `in_valid`. `out_valid` marks which outputs are meaningful.
- There is no backpressure or stall input.
- `rst_n` low asserts all outputs to 0 immediately, without waiting for a clock edge: `result`, `zero`, `carry`, `neg`, `gctl`, `pc_plus4`, `br_target`, `out_valid`. Outputs hold 0 while `rst_n` is low.
- The first capture after reset release is at the first rising edge at which `rst_n` is high.
- Reset asserted between edges discards the in-flight result.

## Test plan
- Reset: drive `rst_n` = 0 mid-cycle with nonzero registers → all outputs 0 before the next edge. Release reset; `pc = 0` → after the next edge, `pc_plus4 = 4`.
- lw/sw add: `aluop = 00`, `op_a = 0x10`, `op_b = 0x4` → `gctl = 010`, `result = 0x14`, `zero = 0`, `carry = 0`.
- beq subtract: `aluop = 01`, `op_a = op_b = 0x1234` → `gctl = 110`, `result = 0`, `zero = 1`, `carry = 1`. Same cycle `pc = 0x8`, `imm16 = 0xFFFE` → `br_target = 0x4`.
- R-type decode sweep, `aluop = 10`:
  - `funct = 0000` → 010.
  - `funct = 0010` → 110.
  - `funct = 0100` → 000.
  - `funct = 0101` → 001.
  - `funct = 1010` → 111.
  - `funct = 0110` → 000 (the later rule overrides).
- slt signed: `op_a = 0xFFFFFFFF` (−1), `op_b = 1`, slt code → `result = 1`. With the operands swapped → `result = 0`, `zero = 1`.
- Wrap and flags: add `0xFFFFFFFF + 1` → `result = 0`, `carry = 1`, `zero = 1`. `pc = 0xFFFFFFFC` → `pc_plus4 = 0`. AND `0xF0F0F0F0 & 0x8F0F0F0F` → `result = 0x80000000`, `neg = 1`. Check that `out_valid` tracks `in_valid` with exactly 1-cycle delay.
